// File: rtl/alu_cfg_pkg.sv
// Shared types and constants for the PE configuration frame loader.
package alu_cfg_pkg;

  localparam int unsigned ALU_FUNC_MAX = 5;
  localparam logic [15:0] CFG_SYNC     = 16'hFAB0;

  typedef struct packed {
    logic       rst_tie;
    logic       en_tie;
    logic [2:0] alu_func;
  } pe_cfg_t;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} cfg_state_t;

  localparam pe_cfg_t PE_CFG_RESET = '{rst_tie: 1'b1, en_tie: 1'b1, alu_func: 3'd0};

endpackage

// File: rtl/alu_cfg_loader_frame_fsm.sv
// Frame parser: handshake, state, entry count, running XOR and the bad-frame flag.
module cfg_frame_fsm
  import alu_cfg_pkg::*;
#(
  parameter int unsigned NUM_PE = 16,
  parameter logic [15:0] SYNC   = CFG_SYNC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        cfg_commit,
  output logic        cfg_error,
  output logic        hdr_load,
  output logic        entry_wr,
  output logic        commit_en,
  output logic [7:0]  entry_addr,
  output pe_cfg_t     entry_cfg
);

  cfg_state_t  state;
  cfg_state_t  next;
  logic [15:0] cnt;
  logic [31:0] run_xor;
  logic        bad;
  logic        hs;
  logic        entry_ok;
  logic        good;

  assign hs         = in_valid & in_ready;
  assign entry_addr = in_data[31:24];
  assign entry_cfg  = pe_cfg_t'(in_data[4:0]);
  assign entry_ok   = (32'(in_data[31:24]) < NUM_PE) && (32'(in_data[2:0]) <= ALU_FUNC_MAX);
  assign good       = (in_data == run_xor) && !bad;

  always_comb begin
    next      = state;
    hdr_load  = 1'b0;
    entry_wr  = 1'b0;
    commit_en = 1'b0;
    case (state)
      IDLE: begin
        if (hs && in_data[31:16] == SYNC) begin
          hdr_load = 1'b1;
          next     = (in_data[15:0] == 16'd0) ? CHECK : LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          entry_wr = entry_ok;
          if (cnt == 16'd1) next = CHECK;
        end
      end
      CHECK: begin
        if (hs) begin
          commit_en = good;
          next      = DONE;
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // in_ready/busy are registered from next so they come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      run_xor    <= '0;
      bad        <= 1'b0;
      cfg_error  <= 1'b0;
      cfg_commit <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= next;
      cfg_commit <= commit_en;
      in_ready   <= (next != DONE);
      busy       <= (next != IDLE);
      if (hdr_load) begin
        run_xor   <= in_data;
        cnt       <= in_data[15:0];
        bad       <= 1'b0;
        cfg_error <= 1'b0;
      end
      if (state == LOAD && hs) begin
        run_xor <= run_xor ^ in_data;
        cnt     <= cnt - 16'd1;
        if (!entry_ok) bad <= 1'b1;
      end
      if (state == CHECK && hs && !good) cfg_error <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_cfg_loader.sv
// PE configuration loader: shadow/active config arrays fed by the frame parser.
module alu_cfg_loader
  import alu_cfg_pkg::*;
#(
  parameter int unsigned NUM_PE = 16,
  parameter logic [15:0] SYNC   = CFG_SYNC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [3*NUM_PE-1:0] alu_func_o,
  output logic [NUM_PE-1:0]   reg_en_tie_o,
  output logic [NUM_PE-1:0]   reg_rst_tie_o,
  output logic                cfg_commit,
  output logic                cfg_error,
  output logic                busy
);

  pe_cfg_t    shadow [NUM_PE];
  pe_cfg_t    active [NUM_PE];
  logic       hdr_load;
  logic       entry_wr;
  logic       commit_en;
  logic [7:0] entry_addr;
  pe_cfg_t    entry_cfg;

  cfg_frame_fsm #(
    .NUM_PE(NUM_PE),
    .SYNC  (SYNC)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .cfg_commit(cfg_commit),
    .cfg_error (cfg_error),
    .hdr_load  (hdr_load),
    .entry_wr  (entry_wr),
    .commit_en (commit_en),
    .entry_addr(entry_addr),
    .entry_cfg (entry_cfg)
  );

  // Header load, entry write and commit occur in distinct states, never together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        shadow[i] <= PE_CFG_RESET;
        active[i] <= PE_CFG_RESET;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (hdr_load)
          shadow[i] <= active[i];
        else if (entry_wr && entry_addr == 8'(i))
          shadow[i] <= entry_cfg;
        if (commit_en)
          active[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    alu_func_o    = '0;
    reg_en_tie_o  = '0;
    reg_rst_tie_o = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      alu_func_o[3*i +: 3] = active[i].alu_func;
      reg_en_tie_o[i]      = active[i].en_tie;
      reg_rst_tie_o[i]     = active[i].rst_tie;
    end
  end

endmodule

// File: tb/tb_alu_cfg_loader.sv
// Self-checking bench: directed frame table, hand sequences and random frames vs a frame-level model.
module tb_alu_cfg_loader;

  localparam int unsigned NPE = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3*NPE-1:0]  alu_func_o;
  logic [NPE-1:0]    reg_en_tie_o;
  logic [NPE-1:0]    reg_rst_tie_o;
  logic              cfg_commit;
  logic              cfg_error;
  logic              busy;

  always #5 clk = ~clk;

  alu_cfg_loader #(.NUM_PE(NPE), .SYNC(16'hFAB0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_func_o(alu_func_o), .reg_en_tie_o(reg_en_tie_o), .reg_rst_tie_o(reg_rst_tie_o),
    .cfg_commit(cfg_commit), .cfg_error(cfg_error), .busy(busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [2:0]  m_func [NPE];
  logic        m_en   [NPE];
  logic        m_rst  [NPE];
  logic [31:0] frame  [$];

  typedef struct {
    string       tag;
    int unsigned nw;
    logic [31:0] w [4];
    bit          exp_good;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPE; i++) begin
      m_func[i] = 3'd0; m_en[i] = 1'b1; m_rst[i] = 1'b1;
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [3*NPE-1:0] ef;
    logic [NPE-1:0]   ee, er;
    for (int i = 0; i < NPE; i++) begin
      ef[3*i +: 3] = m_func[i]; ee[i] = m_en[i]; er[i] = m_rst[i];
    end
    chk({tag, "_alu_func"}, 64'(alu_func_o), 64'(ef));
    chk({tag, "_en_tie"}, 64'(reg_en_tie_o), 64'(ee));
    chk({tag, "_rst_tie"}, 64'(reg_rst_tie_o), 64'(er));
  endtask

  // Whole-frame view: good iff header/count/XOR match and every entry is legal.
  function automatic bit model_frame();
    logic [31:0] x = '0;
    bit ok;
    int unsigned last = frame.size() - 1;
    int unsigned a;
    for (int unsigned k = 0; k < last; k++) x ^= frame[k];
    ok = (x == frame[last]) && (frame[0][31:16] == 16'hFAB0) && (frame[0][15:0] == 16'(last - 1));
    for (int unsigned k = 1; k < last; k++)
      if (frame[k][31:24] >= NPE || frame[k][2:0] > 3'd5) ok = 1'b0;
    if (ok)
      for (int unsigned k = 1; k < last; k++) begin
        a = 32'(frame[k][31:24]);
        m_func[a] = frame[k][2:0]; m_en[a] = frame[k][3]; m_rst[a] = frame[k][4];
      end
    return ok;
  endfunction

  task automatic send_word(input logic [31:0] w, input int unsigned gap_max);
    int unsigned waited = 0;
    @(negedge clk);
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waited);
    end else begin
      in_data = w; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = $urandom;
    end
  endtask

  task automatic run_frame(input string tag, input int unsigned gap_max, input bit exp_good);
    for (int unsigned k = 0; k < frame.size(); k++) send_word(frame[k], gap_max);
    chk_outputs(tag);
    chk({tag, "_commit"}, 64'(cfg_commit), 64'(exp_good));
    chk({tag, "_error"}, 64'(cfg_error), 64'(!exp_good));
    chk({tag, "_done_ready"}, 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_commit_drop"}, 64'(cfg_commit), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_error_hold"}, 64'(cfg_error), 64'(!exp_good));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          g;
    logic [31:0] r;
    int unsigned n, addr, fn;

    tbl[0].tag = "T2"; tbl[0].nw = 4; tbl[0].exp_good = 1'b1;
    tbl[0].w[0] = 32'hFAB0_0002; tbl[0].w[1] = 32'h0100_0002; tbl[0].w[2] = 32'h0300_0015; tbl[0].w[3] = 32'hF8B0_0015;
    tbl[1].tag = "T3"; tbl[1].nw = 4; tbl[1].exp_good = 1'b0;
    tbl[1].w[0] = 32'hFAB0_0002; tbl[1].w[1] = 32'h0100_0002; tbl[1].w[2] = 32'h0300_0015; tbl[1].w[3] = 32'hF8B0_0014;
    tbl[2].tag = "T4f"; tbl[2].nw = 3; tbl[2].exp_good = 1'b0;
    tbl[2].w[0] = 32'hFAB0_0001; tbl[2].w[1] = 32'h0200_0006; tbl[2].w[2] = 32'hF8B0_0007; tbl[2].w[3] = '0;
    tbl[3].tag = "T4a"; tbl[3].nw = 3; tbl[3].exp_good = 1'b0;
    tbl[3].w[0] = 32'hFAB0_0001; tbl[3].w[1] = 32'h2000_0001; tbl[3].w[2] = 32'hDAB0_0000; tbl[3].w[3] = '0;
    tbl[4].tag = "T5"; tbl[4].nw = 2; tbl[4].exp_good = 1'b1;
    tbl[4].w[0] = 32'hFAB0_0000; tbl[4].w[1] = 32'hFAB0_0000; tbl[4].w[2] = '0; tbl[4].w[3] = '0;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs("T1");
    chk("T1_ready", 64'(in_ready), 64'd1);
    chk("T1_busy", 64'(busy), 64'd0);
    chk("T1_error", 64'(cfg_error), 64'd0);
    chk("T1_commit", 64'(cfg_commit), 64'd0);

    for (int i = 0; i < 5; i++) begin
      send_word(32'h1234_5678, 0);
      chk({tbl[i].tag, "_junk_busy"}, 64'(busy), 64'd0);
      frame.delete();
      for (int unsigned k = 0; k < tbl[i].nw; k++) frame.push_back(tbl[i].w[k]);
      g = model_frame();
      run_frame(tbl[i].tag, 0, tbl[i].exp_good);
      if (i == 0) begin
        chk("T2_pe1_func", 64'(alu_func_o[5:3]), 64'd2);
        chk("T2_pe1_rst", 64'(reg_rst_tie_o[1]), 64'd0);
        chk("T2_pe3_func", 64'(alu_func_o[11:9]), 64'd5);
        chk("T2_pe3_en", 64'(reg_en_tie_o[3]), 64'd0);
        chk("T2_pe3_rst", 64'(reg_rst_tie_o[3]), 64'd1);
      end
    end

    send_word(32'hFAB0_0000, 0);
    chk("T3_hdr_clears_error", 64'(cfg_error), 64'd0);
    chk("T3_hdr_busy", 64'(busy), 64'd1);
    frame.delete();
    frame.push_back(32'hFAB0_0000);
    frame.push_back(32'hFAB0_0000);
    g = model_frame();
    frame.delete();
    frame.push_back(32'hFAB0_0000);
    run_frame("T3_clear", 0, 1'b1);

    send_word(32'hFAB0_0002, 0);
    send_word(32'h0500_0013, 0);
    chk("T6_midload_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_outputs("T6_rst");
    chk("T6_rst_busy", 64'(busy), 64'd0);
    chk("T6_rst_ready", 64'(in_ready), 64'd1);
    chk("T6_rst_error", 64'(cfg_error), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    frame.delete();
    for (int unsigned k = 0; k < 4; k++) frame.push_back(tbl[0].w[k]);
    g = model_frame();
    run_frame("T6_gaps", 3, g);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(3, 0) == 0) begin
        r = $urandom;
        send_word({16'h1234, r[15:0]}, 1);
      end
      frame.delete();
      n = $urandom_range(5, 0);
      frame.push_back({16'hFAB0, 16'(n)});
      for (int unsigned k = 0; k < n; k++) begin
        addr = ($urandom_range(9, 0) == 0) ? $urandom_range(255, 16) : $urandom_range(15, 0);
        fn   = ($urandom_range(9, 0) == 0) ? $urandom_range(7, 6) : $urandom_range(5, 0);
        r = $urandom;
        frame.push_back({8'(addr), r[18:0], r[31:30], 3'(fn)});
      end
      r = '0;
      for (int unsigned k = 0; k < frame.size(); k++) r ^= frame[k];
      if ($urandom_range(5, 0) == 0) r[$urandom_range(31, 0)] ^= 1'b1;
      frame.push_back(r);
      g = model_frame();
      run_frame($sformatf("R%0d", f), 2, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
